// File: rtl/sram_like_pkg.sv
// Shared definitions for the SRAM-like data-bus responder: access sizes,
// handshake states and the byte-lane decode used on every accepted request.
package sram_like_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0] be;
    logic       mis;
  } byte_en_t;

  function automatic byte_en_t byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
    byte_en_t r;
    r.be  = 4'b0000;
    r.mis = 1'b0;
    case (size)
      SIZE_BYTE: r.be = 4'b0001 << addr_lo;
      SIZE_HALF: begin
        if (addr_lo == 2'b00) begin
          r.be = 4'b0011;
        end else if (addr_lo == 2'b10) begin
          r.be = 4'b1100;
        end else begin
          r.mis = 1'b1;
        end
      end
      SIZE_WORD: begin
        if (addr_lo == 2'b00) begin
          r.be = 4'b1111;
        end else begin
          r.mis = 1'b1;
        end
      end
      default: r.mis = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sram_like_ram_slave_byte_we_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port
// whose output holds until the next read.
module byte_we_ram #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem_r [2**ADDR_WIDTH];
  logic [31:0] rdata_r;

  // Byte-lane writes; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read hold register, updated only on read accesses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r <= 32'd0;
    end else if (re) begin
      rdata_r <= mem_r[addr];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/sram_like_ram_slave.sv
// Responder for the SRAM-like data bus: one outstanding request, serviced
// against a byte-writable RAM, completed with data_ok after LATENCY cycles.
module sram_like_ram_slave
  import sram_like_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        misalign_err
);

  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_e      state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic        mis_r;
  logic        addr_ok_s, accept_s, resp_mis_s, re_s;
  logic [3:0]  we_s;
  byte_en_t    be_s;
  logic [31:0] ram_q_s;
  logic        data_ok_r, misalign_r;

  // Handshake decode and RAM controls for the request on the bus this cycle.
  always_comb begin
    addr_ok_s = 1'b0;
    if (rst) begin
      addr_ok_s = 1'b0;
    end else if (state_r == IDLE || state_r == RESP) begin
      addr_ok_s = 1'b1;
    end else begin
      addr_ok_s = 1'b0;
    end
    accept_s   = data_req && addr_ok_s;
    be_s       = byte_en(data_size, data_addr[1:0]);
    we_s       = (accept_s && data_wr) ? be_s.be : 4'b0000;
    re_s       = accept_s && !data_wr;
    resp_mis_s = accept_s ? be_s.mis : mis_r;
  end

  // Next-state and latency counter.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE, RESP: begin
        if (accept_s) begin
          if (LATENCY == 1) begin
            state_s = RESP;
          end else begin
            state_s = WAIT;
            cnt_s   = CNT_INIT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd0) begin
          state_s = RESP;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, request attributes and registered completion flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      mis_r      <= 1'b0;
      data_ok_r  <= 1'b0;
      misalign_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      mis_r      <= accept_s ? be_s.mis : mis_r;
      data_ok_r  <= (state_s == RESP);
      misalign_r <= (state_s == RESP) && resp_mis_s;
    end
  end

  byte_we_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we_s),
    .re    (re_s),
    .addr  (data_addr[ADDR_WIDTH+1:2]),
    .wdata (data_wdata),
    .rdata (ram_q_s)
  );

  // With a one-cycle latency the RAM hold register already updates on the
  // edge entering RESP; longer latencies copy it out on that edge instead.
  if (LATENCY == 1) begin : g_direct
    assign data_rdata = ram_q_s;
  end else begin : g_hold
    logic        wr_r;
    logic [31:0] rdata_r;

    // Read-response data register.
    always_ff @(posedge clk) begin
      if (rst) begin
        wr_r    <= 1'b0;
        rdata_r <= 32'd0;
      end else begin
        wr_r    <= accept_s ? data_wr : wr_r;
        rdata_r <= (state_s == RESP && !wr_r) ? ram_q_s : rdata_r;
      end
    end

    assign data_rdata = rdata_r;
  end

  assign data_addr_ok = addr_ok_s;
  assign data_data_ok = data_ok_r;
  assign misalign_err = misalign_r;

endmodule

// File: tb/tb_sram_like_ram_slave.sv
// Randomised self-checking bench: three responders (latency 1, 4, 3) checked
// against a byte-level memory model and the handshake timing rules.
module tb_sram_like_ram_slave;

  localparam int LAT [3] = '{1, 4, 3};

  logic        clk;
  logic        rst     [3];
  logic        req     [3];
  logic        wr      [3];
  logic [1:0]  size    [3];
  logic [31:0] addr    [3];
  logic [31:0] wdata   [3];
  logic [31:0] rdata   [3];
  logic        addr_ok [3];
  logic        data_ok [3];
  logic        mis     [3];

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem_m [int];
  logic [31:0] last_rd [3];

  sram_like_ram_slave #(.ADDR_WIDTH(12), .LATENCY(1)) dut0 (
    .clk(clk), .rst(rst[0]), .data_req(req[0]), .data_wr(wr[0]), .data_size(size[0]),
    .data_addr(addr[0]), .data_wdata(wdata[0]), .data_rdata(rdata[0]),
    .data_addr_ok(addr_ok[0]), .data_data_ok(data_ok[0]), .misalign_err(mis[0]));

  sram_like_ram_slave #(.ADDR_WIDTH(12), .LATENCY(4)) dut1 (
    .clk(clk), .rst(rst[1]), .data_req(req[1]), .data_wr(wr[1]), .data_size(size[1]),
    .data_addr(addr[1]), .data_wdata(wdata[1]), .data_rdata(rdata[1]),
    .data_addr_ok(addr_ok[1]), .data_data_ok(data_ok[1]), .misalign_err(mis[1]));

  sram_like_ram_slave #(.ADDR_WIDTH(12), .LATENCY(3)) dut2 (
    .clk(clk), .rst(rst[2]), .data_req(req[2]), .data_wr(wr[2]), .data_size(size[2]),
    .data_addr(addr[2]), .data_wdata(wdata[2]), .data_rdata(rdata[2]),
    .data_addr_ok(addr_ok[2]), .data_data_ok(data_ok[2]), .misalign_err(mis[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int mkey(input int i, input logic [31:0] a);
    return i * 4096 + int'((a >> 2) & 32'hFFF);
  endfunction

  // Model effect of an accepted request; returns 1 when the access is aligned.
  function automatic bit model_access(input int i, input bit w, input logic [1:0] sz,
                                      input logic [31:0] a, input logic [31:0] wd);
    int nb, off, k;
    bit al;
    logic [31:0] word;
    nb  = (sz == 2'd3) ? 0 : (1 << sz);
    off = int'(a & 32'd3);
    al  = (sz != 2'd3) && ((off % nb) == 0);
    k   = mkey(i, a);
    word = mem_m.exists(k) ? mem_m[k] : 32'h0;
    if (w && al) begin
      for (int b = off; b < off + nb; b++) word[8*b +: 8] = wd[8*b +: 8];
      mem_m[k] = word;
    end
    if (!w) last_rd[i] = word;
    return al;
  endfunction

  task automatic issue(input int i, input bit w, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd, input string name);
    int n, k;
    bit acc, al;
    @(negedge clk);
    req[i] = 1'b1; wr[i] = w; size[i] = sz; addr[i] = a; wdata[i] = wd;
    n = 0; acc = 1'b0;
    while (!acc && n < 20) begin
      #1 acc = addr_ok[i];
      @(posedge clk);
      n++;
    end
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL %s_accept: addr_ok never high within %0d cycles", name, n);
      req[i] = 1'b0;
      return;
    end
    al = model_access(i, w, sz, a, wd);
    #1 req[i] = 1'b0;
    k = 0;
    while (data_ok[i] !== 1'b1 && k < 20) begin
      checks++;
      if (addr_ok[i] !== 1'b0) begin
        failures++;
        $display("FAIL %s_wait_addr_ok: got %b expected 0", name, addr_ok[i]);
      end
      @(posedge clk);
      #1 k++;
    end
    checks++;
    if (k != LAT[i] - 1) begin
      failures++;
      $display("FAIL %s_latency: got %0d extra cycles expected %0d", name, k, LAT[i] - 1);
      return;
    end
    checks++;
    if (mis[i] !== !al) begin
      failures++;
      $display("FAIL %s_misalign: got %b expected %b", name, mis[i], !al);
    end
    checks++;
    if (rdata[i] !== last_rd[i]) begin
      failures++;
      $display("FAIL %s_rdata: got %h expected %h", name, rdata[i], last_rd[i]);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (addr_ok[i] !== 1'b0 || data_ok[i] !== 1'b0 || mis[i] !== 1'b0 || rdata[i] !== 32'h0) begin
        failures++;
        $display("FAIL reset_values%0d: got addr_ok=%b data_ok=%b mis=%b rdata=%h expected 0/0/0/0",
                 i, addr_ok[i], data_ok[i], mis[i], rdata[i]);
      end
      rst[i] = 1'b0;
      last_rd[i] = 32'h0;
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (addr_ok[i] !== 1'b1) begin
        failures++;
        $display("FAIL idle_addr_ok%0d: got %b expected 1", i, addr_ok[i]);
      end
    end
  endtask

  task automatic test_basic();
    issue(0, 1'b1, 2'b10, 32'h100, 32'hDEADBEEF, "basic_wr");
    issue(0, 1'b0, 2'b10, 32'h100, 32'h0, "basic_rd");
    checks++;
    if (rdata[0] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL basic_value: got %h expected deadbeef", rdata[0]);
    end
  endtask

  task automatic test_back_to_back();
    bit al;
    @(negedge clk);
    req[0] = 1'b1; wr[0] = 1'b1; size[0] = 2'b10; addr[0] = 32'h104; wdata[0] = 32'hCAFEF00D;
    #1 checks++;
    if (addr_ok[0] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first_addr_ok: got %b expected 1", addr_ok[0]);
    end
    @(posedge clk);
    al = model_access(0, 1'b1, 2'b10, 32'h104, 32'hCAFEF00D);
    #1 checks++;
    if (data_ok[0] !== 1'b1 || addr_ok[0] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_write_resp: got data_ok=%b addr_ok=%b expected 1/1", data_ok[0], addr_ok[0]);
    end
    wr[0] = 1'b0;
    @(posedge clk);
    al = model_access(0, 1'b0, 2'b10, 32'h104, 32'h0);
    #1 checks++;
    if (data_ok[0] !== 1'b1 || rdata[0] !== 32'hCAFEF00D || mis[0] !== !al) begin
      failures++;
      $display("FAIL b2b_read_resp: got data_ok=%b rdata=%h mis=%b expected 1/cafef00d/0",
               data_ok[0], rdata[0], mis[0]);
    end
    req[0] = 1'b0;
    @(posedge clk);
    #1 checks++;
    if (data_ok[0] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_single_pulse: got %b expected 0", data_ok[0]);
    end
  endtask

  task automatic test_lanes();
    issue(0, 1'b1, 2'b10, 32'h40, 32'h00000000, "lanes_clear");
    issue(0, 1'b1, 2'b00, 32'h43, 32'hAB000000, "lanes_byte");
    issue(0, 1'b1, 2'b01, 32'h40, 32'h00001234, "lanes_half");
    issue(0, 1'b0, 2'b10, 32'h40, 32'h0, "lanes_rd");
    checks++;
    if (rdata[0] !== 32'hAB001234) begin
      failures++;
      $display("FAIL lanes_value: got %h expected ab001234", rdata[0]);
    end
  endtask

  task automatic test_misaligned();
    issue(0, 1'b1, 2'b01, 32'h41, 32'hFFFFFFFF, "mis_wr");
    issue(0, 1'b0, 2'b10, 32'h42, 32'h0, "mis_rd");
    checks++;
    if (rdata[0] !== 32'hAB001234) begin
      failures++;
      $display("FAIL mis_unchanged: got %h expected ab001234", rdata[0]);
    end
    issue(0, 1'b1, 2'b11, 32'h40, 32'hFFFFFFFF, "illegal_size_wr");
    issue(0, 1'b0, 2'b10, 32'h40, 32'h0, "illegal_size_rd");
  endtask

  task automatic test_alias();
    issue(0, 1'b1, 2'b10, 32'h4000, 32'h5A5A5A5A, "alias_wr");
    issue(0, 1'b0, 2'b10, 32'h0000, 32'h0, "alias_rd");
    checks++;
    if (rdata[0] !== 32'h5A5A5A5A) begin
      failures++;
      $display("FAIL alias_value: got %h expected 5a5a5a5a", rdata[0]);
    end
  endtask

  task automatic test_latency4();
    logic [31:0] v;
    int n;
    bit acc, exp_ok;
    v = $urandom();
    issue(1, 1'b1, 2'b10, 32'h20, v, "lat4_wr");
    @(negedge clk);
    req[1] = 1'b1; wr[1] = 1'b0; size[1] = 2'b10; addr[1] = 32'h20;
    n = 0; acc = 1'b0;
    while (!acc && n < 20) begin
      #1 acc = addr_ok[1];
      @(posedge clk);
      n++;
    end
    for (int k = 0; k < 12; k++) begin
      exp_ok = (k % 4 == 3);
      #1 checks++;
      if (data_ok[1] !== exp_ok || addr_ok[1] !== exp_ok) begin
        failures++;
        $display("FAIL lat4_cycle%0d: got data_ok=%b addr_ok=%b expected %b/%b",
                 k, data_ok[1], addr_ok[1], exp_ok, exp_ok);
      end
      if (exp_ok) begin
        checks++;
        if (rdata[1] !== v) begin
          failures++;
          $display("FAIL lat4_rdata%0d: got %h expected %h", k, rdata[1], v);
        end
      end
      if (k == 11) req[1] = 1'b0;
      @(posedge clk);
    end
    last_rd[1] = v;
    #1 checks++;
    if (data_ok[1] !== 1'b0 || addr_ok[1] !== 1'b1) begin
      failures++;
      $display("FAIL lat4_idle: got data_ok=%b addr_ok=%b expected 0/1", data_ok[1], addr_ok[1]);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic [1:0] sz;
    bit w;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 16; k++) issue(i, 1'b1, 2'b10, 32'h200 + 32'(4 * k), $urandom(), "rand_init");
      for (int k = 0; k < 30; k++) begin
        a  = ($urandom() & 32'hFFFFC000) | (32'h200 + 32'($urandom_range(0, 63)));
        d  = $urandom();
        sz = 2'($urandom_range(0, 3));
        w  = 1'($urandom_range(0, 1));
        issue(i, w, sz, a, d, w ? "rand_wr" : "rand_rd");
      end
    end
  endtask

  task automatic test_reset_mid();
    bit al;
    issue(2, 1'b1, 2'b10, 32'h10, 32'hA5A50F0F, "mid_pre_wr");
    issue(2, 1'b0, 2'b10, 32'h10, 32'h0, "mid_pre_rd");
    @(negedge clk);
    req[2] = 1'b1; wr[2] = 1'b1; size[2] = 2'b10; addr[2] = 32'h8; wdata[2] = 32'h11223344;
    #1 checks++;
    if (addr_ok[2] !== 1'b1) begin
      failures++;
      $display("FAIL mid_addr_ok: got %b expected 1", addr_ok[2]);
    end
    @(posedge clk);
    al = model_access(2, 1'b1, 2'b10, 32'h8, 32'h11223344);
    #1 req[2] = 1'b0;
    @(posedge clk);
    #1 rst[2] = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst[2] = 1'b0;
    last_rd[2] = 32'h0;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (data_ok[2] !== 1'b0 || rdata[2] !== 32'h0) begin
        failures++;
        $display("FAIL mid_dropped%0d: got data_ok=%b rdata=%h expected 0/0", k, data_ok[2], rdata[2]);
      end
      @(posedge clk);
      #1;
    end
    issue(2, 1'b0, 2'b10, 32'h8, 32'h0, "mid_rd");
    checks++;
    if (rdata[2] !== 32'h11223344) begin
      failures++;
      $display("FAIL mid_committed: got %h expected 11223344", rdata[2]);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; req[i] = 1'b0; wr[i] = 1'b0; size[i] = 2'b00;
      addr[i] = 32'h0; wdata[i] = 32'h0; last_rd[i] = 32'h0;
    end
    test_reset();
    test_basic();
    test_back_to_back();
    test_lanes();
    test_misaligned();
    test_alias();
    test_latency4();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_like_ram_slave.md
Name: sram_like_ram_slave

Overview:
- Responder end of the SRAM-like data bus: data_req/wr/size/addr/wdata in, data_rdata/addr_ok/data_ok out.
- Stands in place of the data-side memory behind the MEM stage's data port.
- Accepts one request per handshake and services it against an internal byte-writable word RAM.
- Returns data_ok after a programmable latency.
- Used as the on-chip data RAM in simulation and in cache-less builds.

Parameters:
- ADDR_WIDTH, 12: word-index bits; the RAM holds 2**ADDR_WIDTH 32-bit words.
- LATENCY, 1: cycles from the accepting edge to data_ok. Legal range 1..15.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- data_req  input  1  request valid
- data_wr  input  1  1 = write, 0 = read
- data_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
- data_addr  input  32  byte address
- data_wdata  input  32  write data, already placed in its byte lanes
- data_rdata  output  32  read data, full aligned word
- data_addr_ok  output  1  request accepted this cycle when data_req is also high
- data_data_ok  output  1  one-cycle completion pulse, one per accepted request
- misalign_err  output  1  pulses together with data_ok for a misaligned or illegal-size request

Behaviour:
- Reset values: data_rdata=0, data_addr_ok=0 during rst, data_data_ok=0, misalign_err=0, state=IDLE. RAM contents are not reset.
- Handshake: a request is accepted at a rising edge where data_req && data_addr_ok. Request fields are sampled only at that edge.
- At most one request is outstanding.
- data_addr_ok is combinational: high in IDLE, and high in RESP (the data_ok cycle). This allows back-to-back acceptance.
- States:
  - IDLE: on accept, go to RESP if LATENCY==1, else go to WAIT with cnt=LATENCY-2.
  - WAIT: if cnt==0 go to RESP, else cnt-=1. data_addr_ok=0.
  - RESP: data_data_ok=1 for exactly this cycle. On a new accept, follow the IDLE rules. Otherwise go to IDLE.
- Word index = data_addr[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses alias modulo 4*2**ADDR_WIDTH.
- Byte enables:
  - size 00: one lane, selected by addr[1:0].
  - size 01: addr[1:0]=00 gives 0011; addr[1:0]=10 gives 1100.
  - size 10 with addr[1:0]=00: 1111.
  - Any other size/offset combination is misaligned: enables 0000, and the request is flagged.
- Writes commit to the RAM at the accepting edge, enabled lanes only. A read accepted in a write's RESP cycle sees the new data.
- Reads index the RAM at the accepting edge and capture the full word into a hold register. data_rdata takes that word in RESP.
- data_rdata changes only on read responses. It holds its value through write responses and idle cycles.
- Misaligned read: returns the aligned word normally, with misalign_err=1.
- Misaligned write: no RAM change; data_ok is still given, with misalign_err=1.
- data_req dropping while not accepted is legal and has no effect.
- Reset mid-request (WAIT or RESP): the outstanding response is dropped and no data_ok follows. Any write already committed remains.

Decomposition:
- Package sram_like_pkg holds:
  - size constants SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10;
  - the state enum {IDLE, WAIT, RESP};
  - a function byte_en(size, addr_lo) returning a 4-bit mask plus a misaligned flag.
- One sub-module, byte_we_ram: single-port RAM with 4-bit byte write enable and a synchronous read port, parameterised by ADDR_WIDTH.

Test Plan:
- LATENCY=1:
  - Stimulus: word write 0xDEADBEEF at 0x100; next cycle, read 0x100.
  - Response: data_ok one cycle after each accept; read returns 0xDEADBEEF; addr_ok high continuously; two accepts on consecutive edges.
- Byte/half lanes:
  - Stimulus: after a word write of 0x00000000 at 0x40, write byte size=00 addr=0x43 wdata=0xAB000000, then half size=01 addr=0x40 wdata=0x00001234.
  - Response: a read of 0x40 returns 0xAB001234.
- Misaligned:
  - Stimulus: half write at 0x41 with wdata=0xFFFFFFFF, then word read at 0x42.
  - Response: both complete; misalign_err=1 on both data_ok cycles; RAM word 0x40 unchanged; the read returns the 0x40 word.
- LATENCY=4:
  - Stimulus: read request held high continuously.
  - Response: data_ok exactly 4 cycles after each accept; addr_ok low during WAIT; accepts spaced 4 cycles apart.
- Reset mid-operation:
  - Stimulus: LATENCY=3; write 0x11223344 to 0x8; assert rst one cycle later.
  - Response: no data_ok; data_rdata=0; a subsequent read of 0x8 returns 0x11223344.
- Aliasing:
  - Stimulus: ADDR_WIDTH=12; write 0x5A5A5A5A to 0x4000; read 0x0000.
  - Response: the read returns 0x5A5A5A5A.
